// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWwait,
    StSetup,
    StAccess
  } state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'h8000_0000;
  localparam logic [31:0] DefaultSlvSize  = 32'h0400_0000;
  localparam logic [1:0]  HrespOkay       = 2'b00;

endpackage

// File: rtl/ahb_apb_ctrl_fsm_if.sv
// Bus bundle between the AHB slave interface / APB fabric and the bridge sequencer.
interface ahb_apb_ctrl_fsm_if #(
  parameter int unsigned NUM_SLV = 3
);
  logic               valid;
  logic [31:0]        Haddr;
  logic               Hwrite;
  logic [31:0]        Hwdata;
  logic [31:0]        Prdata;
  logic               Pready;
  logic               Hreadyout;
  logic [31:0]        Hrdata;
  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [31:0]        Paddr;
  logic [31:0]        Pwdata;
  logic               timeout_err;

  modport master (
    output valid, Haddr, Hwrite, Hwdata, Prdata, Pready,
    input  Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata, timeout_err
  );

  modport slave (
    input  valid, Haddr, Hwrite, Hwdata, Prdata, Pready,
    output Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata, timeout_err
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decode into a one-hot APB peripheral select.
module apb_addr_decode #(
  parameter int unsigned NUM_SLV   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic [31:0]        i_addr,
  output logic [NUM_SLV-1:0] o_sel
);

  localparam logic [63:0] Base = {32'd0, BASE_ADDR};
  localparam logic [63:0] Size = {32'd0, SLV_SIZE};

  logic [63:0] w_addr;
  assign w_addr = {32'd0, i_addr};

  // 64-bit bounds so a window ending at the top of the address space cannot wrap.
  always_comb begin
    o_sel = '0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (w_addr >= Base + 64'(k) * Size && w_addr < Base + 64'(k + 1) * Size) begin
        o_sel[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_apb_ctrl_fsm.sv
// AHB-to-APB bridge sequencer: one SETUP/ACCESS per AHB transfer, with wait-state timeout.
module ahb_apb_ctrl_fsm
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLV     = 3,
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter logic [31:0] SLV_SIZE    = DefaultSlvSize,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic               Hclk,
  input logic               Hresetn,
  ahb_apb_ctrl_fsm_if.slave bus
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic               r_hreadyout;
  logic [31:0]        r_hrdata;
  logic [NUM_SLV-1:0] r_pselx;
  logic               r_penable;
  logic               r_pwrite;
  logic [31:0]        r_paddr;
  logic [31:0]        r_pwdata;
  logic               r_timeout_err;

  logic [31:0]        w_dec_addr;
  logic [NUM_SLV-1:0] w_dec_sel;
  logic               w_ready;

  // Reads decode the live AHB address; writes decode the latched one in WWAIT.
  assign w_dec_addr = (r_state == StIdle) ? bus.Haddr : r_paddr;

  apb_addr_decode #(
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(BASE_ADDR),
    .SLV_SIZE (SLV_SIZE)
  ) u_decode (
    .i_addr(w_dec_addr),
    .o_sel (w_dec_sel)
  );

  // An unmapped address has no peripheral to answer, so it completes at once.
  assign w_ready = bus.Pready | (r_pselx == '0);

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_hreadyout   <= 1'b1;
      r_hrdata      <= '0;
      r_pselx       <= '0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.valid) begin
            r_paddr     <= bus.Haddr;
            r_pwrite    <= bus.Hwrite;
            r_hreadyout <= 1'b0;
            if (bus.Hwrite) begin
              r_state <= StWwait;
              r_pselx <= '0;
            end else begin
              r_state <= StSetup;
              r_pselx <= w_dec_sel;
            end
          end
        end
        StWwait: begin
          r_pwdata <= bus.Hwdata;
          r_pselx  <= w_dec_sel;
          r_state  <= StSetup;
        end
        StSetup: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= StAccess;
        end
        StAccess: begin
          if (w_ready) begin
            r_state     <= StIdle;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
            if (!r_pwrite) r_hrdata <= bus.Prdata;
          end else if (r_cnt == CntMax) begin
            r_state       <= StIdle;
            r_pselx       <= '0;
            r_penable     <= 1'b0;
            r_hreadyout   <= 1'b1;
            r_hrdata      <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.Hreadyout   = r_hreadyout;
  assign bus.Hrdata      = r_hrdata;
  assign bus.Pselx       = r_pselx;
  assign bus.Penable     = r_penable;
  assign bus.Pwrite      = r_pwrite;
  assign bus.Paddr       = r_paddr;
  assign bus.Pwdata      = r_pwdata;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/ahb_apb_ctrl_fsm.md
Name: ahb_apb_ctrl_fsm

Overview:
- Sequencing controller for the AHB-to-APB bridge.
- Accepts qualified AHB transfers (`valid`, `Haddr`, `Hwrite`, `Hwdata`) from the AHB slave interface and runs one APB SETUP/ACCESS cycle per transfer.
- Stalls the AHB side via `Hreadyout` while an APB transfer is in flight, and returns read data.
- Includes an APB wait-state timeout so a hung peripheral cannot lock the bus.

Parameters:
- NUM_SLV, 3, number of APB peripherals; width of Pselx.
- BASE_ADDR, 32'h8000_0000, start of the APB address window.
- SLV_SIZE, 32'h0400_0000, bytes per peripheral region; region k = BASE_ADDR + k*SLV_SIZE.
- TIMEOUT_CYC, 16, maximum ACCESS cycles with Pready low before abort (>=2).

Ports:
- Hclk  in  1  clock
- Hresetn  in  1  asynchronous, active-low reset
- valid  in  1  qualified transfer request from the AHB slave interface (combinational, already gated by Hreadyin)
- Haddr  in  32  AHB address, sampled when accepted in IDLE
- Hwrite  in  1  AHB direction, sampled with Haddr
- Hwdata  in  32  AHB write data, sampled in WWAIT
- Prdata  in  32  APB read data
- Pready  in  1  APB completion
- Hreadyout  out  1  AHB ready (fed back to Hreadyin)
- Hrdata  out  32  registered read data
- Pselx  out  NUM_SLV  one-hot APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Paddr  out  32  APB address
- Pwdata  out  32  APB write data
- timeout_err  out  1  one-cycle pulse on a timeout abort

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - Hreadyout=1.
  - All other outputs 0.
  - State IDLE, timeout counter 0.
- All outputs are registered. They update on the same edge as the state transition and reflect the state being entered.
- States: IDLE, WWAIT, SETUP, ACCESS.
- IDLE (Hreadyout=1):
  - valid=1 → load Paddr=Haddr, Pwrite=Hwrite.
    - Hwrite=1 → WWAIT, Hreadyout=0, Pselx=0.
    - Hwrite=0 → SETUP, Pselx=decode(Haddr), Hreadyout=0.
  - valid=0 → stay in IDLE, outputs unchanged.
- WWAIT: load Pwdata=Hwdata and Pselx=decode(Paddr), then go to SETUP. The AHB master holds Hwdata because Hreadyout=0.
- SETUP: Penable=1, clear the counter, go to ACCESS.
- ACCESS:
  - Pready=1 → go to IDLE with Pselx=0, Penable=0, Hreadyout=1. If Pwrite=0, also Hrdata<=Prdata.
  - Pready=0 and counter==TIMEOUT_CYC-1 → go to IDLE with Pselx=0, Penable=0, Hreadyout=1, Hrdata<=0, timeout_err=1 for one cycle.
  - Otherwise stay in ACCESS and increment the counter.
  - Pready=1 and timeout in the same cycle: Pready wins, no error.
- Decode:
  - region k (0..NUM_SLV-1) → Pselx bit k.
  - Address outside all regions → Pselx=0. The transfer still sequences, and Pready is treated as 1 in ACCESS (no timeout).
- Hreadyout-low cycles per transfer with Pready=1 throughout:
  - read: 2 (SETUP, ACCESS)
  - write: 3 (WWAIT, SETUP, ACCESS)
- Back-to-back transfers: valid in the IDLE cycle where Hreadyout returns high starts the next transfer immediately. There is no idle APB cycle requirement beyond IDLE itself.
- valid is ignored in every state except IDLE.
- Paddr, Pwrite, Pwdata and Hrdata hold their values between transfers.
- Counter width is clog2(TIMEOUT_CYC). The counter does not wrap within one transfer.
- Hresp is outside this block and is fixed OKAY by the slave interface.

Decomposition:
- Shared package apb_bridge_pkg holds:
  - the state enum (IDLE, WWAIT, SETUP, ACCESS)
  - constants for BASE_ADDR/SLV_SIZE defaults and the HRESP_OKAY encoding
- One sub-module: apb_addr_decode (combinational address → one-hot Pselx, parameterised by NUM_SLV/BASE_ADDR/SLV_SIZE). The top holds the FSM, datapath registers and timeout counter.

Test Plan:
1. Reset mid-ACCESS: assert Hresetn=0 while Pselx=3'b010, Penable=1 → same cycle Pselx=0, Penable=0, Hreadyout=1; after release, state IDLE.
2. Single write, Haddr=32'h8400_0010, Hwdata=32'hA5A5_0001, Pready=1:
   - Hreadyout low for exactly 3 cycles.
   - SETUP shows Pselx=3'b010, Pwrite=1, Penable=0.
   - Next cycle Penable=1 with Paddr/Pwdata stable.
3. Single read, Haddr=32'h8800_0004, Prdata=32'h1234_5678, Pready=1:
   - Pselx=3'b100, Hreadyout low for 2 cycles.
   - Hrdata=32'h1234_5678 when Hreadyout rises.
4. Wait states: read to 32'h8000_0000 with Pready low for 3 ACCESS cycles, then high → Hreadyout low for 5 cycles, correct Hrdata, timeout_err never set.
5. Timeout: Pready held low → after 16 ACCESS cycles, timeout_err pulses once, Pselx=0, Hreadyout=1, Hrdata=0. Separately, Pready rising in that same final cycle → normal completion, no pulse.
6. Back-to-back: write to 32'h8000_0008, immediately followed by a read to 32'h8400_0000 with valid held → second SETUP starts the cycle after Hreadyout returns high, with Pwrite=0 and Pselx=3'b010.
